// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_WAIT_RSP,
      ST_DROP,
      ST_HALT
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int          FIFO_DEPTH = 2;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus between fetch (master) and memory (slave).
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_fifo.sv
// Small {word, pc} buffer between the memory response and decode.
module fetch_fifo
   import instr_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t push_data,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_entry_t  mem_q [FIFO_DEPTH];
   fetch_entry_t  mem_d [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_en, pop_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // A push into a full buffer is accepted when the head leaves in the same cycle.
   assign push_en = push & (~full | pop);
   assign pop_en  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop_en) rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(push_en) - CW'(pop_en);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry buffer, redirect handling.
// IFETCH_MISALIGN_CHK_EN adds the misalign output and the HALT state.
//
// state    | meaning
// ST_FETCH | may issue a request (held stable until granted)
// ST_WAIT  | one request granted, awaiting rvalid
// ST_DROP  | granted request is stale, its response is discarded
// ST_HALT  | misaligned redirect seen, fetching stopped until reset
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   instr_fetch_if.master        imem,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   input  logic                 dec_ready,
   output logic                 instr_valid,
   output logic [31:0]          Instr,
   output logic [31:0]          instr_pc
`ifdef IFETCH_MISALIGN_CHK_EN
   ,
   output logic                 misalign
`endif
);
   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d, hold_addr_q, hold_addr_d, gnt_pc_q, gnt_pc_d;
   logic         req_hold_q, req_hold_d, stale_q, stale_d, run_q;
   logic         fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   fetch_entry_t fifo_head, push_data;
   logic [31:0]  redir_target;
   logic         redir_bad;

`ifdef IFETCH_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;
   assign redir_target = redirect_pc;
   assign redir_bad    = redirect & (redirect_pc[1:0] != 2'b00);
   assign misalign_d   = misalign_q | redir_bad;
   assign misalign     = misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end
`else
   assign redir_target = redirect_pc & 32'hFFFF_FFFC;
   assign redir_bad    = 1'b0;
`endif

   fetch_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (push_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign instr_valid = ~fifo_empty;
   assign Instr       = fifo_empty ? NOP_INSTR : fifo_head.word;
   assign instr_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      hold_addr_d    = hold_addr_q;
      gnt_pc_d       = gnt_pc_q;
      req_hold_d     = 1'b0;
      stale_d        = 1'b0;
      fifo_push      = 1'b0;
      fifo_flush     = redirect;
      fifo_pop       = instr_valid & dec_ready & ~redirect;
      push_data      = '{word: imem.imem_rdata, pc: gnt_pc_q};
      imem.imem_req  = 1'b0;
      imem.imem_addr = req_hold_q ? hold_addr_q : fetch_pc_q;

      case (state_q)
         ST_FETCH: begin
            imem.imem_req = run_q & (req_hold_q | ~fifo_full);
            if (imem.imem_req && imem.imem_gnt) begin
               gnt_pc_d = imem.imem_addr;
               if (redirect || stale_q) begin
                  state_d = ST_DROP;
               end else begin
                  state_d    = ST_WAIT_RSP;
                  fetch_pc_d = imem.imem_addr + 32'd4;
               end
            end else if (imem.imem_req) begin
               // A redirect cannot retract an ungranted request; remember it is stale.
               req_hold_d  = 1'b1;
               hold_addr_d = imem.imem_addr;
               stale_d     = stale_q | redirect;
            end
            if (redirect) fetch_pc_d = redir_target;
         end
         ST_WAIT_RSP: begin
            if (redirect) begin
               fetch_pc_d = redir_target;
               state_d    = imem.imem_rvalid ? ST_FETCH : ST_DROP;
            end else if (imem.imem_rvalid) begin
               fifo_push = 1'b1;
               state_d   = ST_FETCH;
            end
         end
         ST_DROP: begin
            if (redirect)         fetch_pc_d = redir_target;
            if (imem.imem_rvalid) state_d    = ST_FETCH;
         end
         default: begin
         end
      endcase

      if (redir_bad) begin
         state_d    = ST_HALT;
         req_hold_d = 1'b0;
         stale_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FETCH;
         fetch_pc_q  <= RESET_PC;
         hold_addr_q <= RESET_PC;
         gnt_pc_q    <= 32'h0;
         req_hold_q  <= 1'b0;
         stale_q     <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
         gnt_pc_q    <= gnt_pc_d;
         req_hold_q  <= req_hold_d;
         stale_q     <= stale_d;
         run_q       <= 1'b1;
      end
   end
endmodule
